// File: rtl/cgra_obi_port_arbiter.sv
// ---------------------------------------------------------------------------
// cgra_obi_port_arbiter
//
// Purpose:
//   Shares one X-HEEP external-xbar OBI slave port between NREQ CGRA column
//   masters. Round-robin arbitration with a lock on a forwarded-but-ungranted
//   request, and in-order response routing via an outstanding-ID FIFO.
//
// Optional feature (macro CGRA_OBI_ARB_STALL_CNT_EN):
//   When defined, per-requester saturating stall counters are built.
//   When undefined, stall_cnt_o is tied to zero and no counter flops exist.
//
// Ports:
//   clk_i        in   clock
//   rst_ni       in   asynchronous reset, active low
//   req_i        in   NREQ requester OBI requests
//   resp_o       out  NREQ requester OBI responses
//   port_req_o   out  shared downstream OBI request
//   port_resp_i  in   shared downstream OBI response
//   spurious_o   out  sticky flag: rvalid arrived with the ID FIFO empty
//   stall_cnt_o  out  per-requester stall cycle counters
// ---------------------------------------------------------------------------

package cgra_obi_arb_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module cgra_obi_port_arbiter
  import cgra_obi_arb_pkg::*;
#(
  parameter int NREQ            = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  obi_req_t  [NREQ-1:0]             req_i,
  output obi_resp_t [NREQ-1:0]             resp_o,
  output obi_req_t                         port_req_o,
  input  obi_resp_t                        port_resp_i,
  output logic                             spurious_o,
  output logic      [NREQ-1:0][CNT_W-1:0]  stall_cnt_o
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_FW = $clog2(MAX_OUTSTANDING + 1);

  // Pointer increment that wraps at MAX_OUTSTANDING (also correct for depth 1).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      n = '0;
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  logic [IDX_W-1:0]  r_rr_ptr;
  logic              r_lock_valid;
  logic [IDX_W-1:0]  r_lock_id;
  logic [IDX_W-1:0]  r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_FW-1:0] r_count;
  logic              r_spurious;

  logic              w_any_req;
  logic              w_found;
  int                w_scan_j;
  logic [IDX_W-1:0]  w_scan_idx;
  logic [IDX_W-1:0]  w_rr_sel;
  logic [IDX_W-1:0]  w_sel;
  logic              w_fwd;
  logic              w_hs;
  logic              w_pop;
  logic [IDX_W-1:0]  w_head;
  logic [NREQ-1:0]   w_gnt;

  // Round-robin scan starting at r_rr_ptr; a held lock overrides the scan.
  always_comb begin
    w_any_req  = 1'b0;
    w_found    = 1'b0;
    w_scan_j   = 0;
    w_scan_idx = '0;
    w_rr_sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_scan_j   = (int'(r_rr_ptr) + i) % NREQ;
      w_scan_idx = IDX_W'(w_scan_j);
      if (!w_found && req_i[w_scan_idx].req) begin
        w_found  = 1'b1;
        w_rr_sel = w_scan_idx;
      end else begin
        w_rr_sel = w_rr_sel;
      end
      w_any_req = w_any_req | req_i[w_scan_idx].req;
    end
    if (r_lock_valid) begin
      w_sel = r_lock_id;
    end else begin
      w_sel = w_rr_sel;
    end
  end

  // Forward/handshake/pop qualifiers; rst_ni gating keeps gnt low during reset.
  // Forwarding uses only the registered count, so a pop never unblocks a full
  // FIFO in the same cycle (no rvalid->req combinational path).
  always_comb begin
    w_fwd  = rst_ni && w_any_req && (r_count < CNT_FW'(MAX_OUTSTANDING));
    w_hs   = w_fwd && port_resp_i.gnt;
    w_pop  = port_resp_i.rvalid && (r_count != '0);
    w_head = r_fifo[r_rptr];
  end

  // Downstream request mux and per-requester grant/response routing.
  always_comb begin
    port_req_o = '0;
    resp_o     = '0;
    w_gnt      = '0;
    if (w_fwd) begin
      port_req_o     = req_i[w_sel];
      port_req_o.req = 1'b1;
    end else begin
      port_req_o = '0;
    end
    for (int k = 0; k < NREQ; k++) begin
      w_gnt[k]         = w_hs && (w_sel == IDX_W'(k));
      resp_o[k].gnt    = w_gnt[k];
      resp_o[k].rvalid = w_pop && (w_head == IDX_W'(k));
      resp_o[k].rdata  = port_resp_i.rdata;
    end
  end

  // Round-robin pointer and request lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr     <= '0;
      r_lock_valid <= 1'b0;
      r_lock_id    <= '0;
    end else if (w_hs) begin
      r_rr_ptr     <= (w_sel == IDX_W'(NREQ - 1)) ? '0 : (w_sel + IDX_W'(1));
      r_lock_valid <= 1'b0;
    end else if (w_fwd) begin
      r_lock_valid <= 1'b1;
      r_lock_id    <= w_sel;
    end
  end

  // Outstanding-ID FIFO: push on handshake, pop on routed rvalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      if (w_hs) begin
        r_fifo[r_wptr] <= w_sel;
        r_wptr         <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + CNT_FW'(1);
        2'b01:   r_count <= r_count - CNT_FW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky spurious-response flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_spurious <= 1'b0;
    end else if (port_resp_i.rvalid && (r_count == '0)) begin
      r_spurious <= 1'b1;
    end
  end

  assign spurious_o = r_spurious;

`ifdef CGRA_OBI_ARB_STALL_CNT_EN
  logic [NREQ-1:0][CNT_W-1:0] r_stall_cnt;

  // Saturating per-requester stall counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (req_i[k].req && !w_gnt[k] && (r_stall_cnt[k] != {CNT_W{1'b1}})) begin
          r_stall_cnt[k] <= r_stall_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cgra_obi_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cgra_obi_port_arbiter
//
// Directed vector table plus hand-written multi-cycle sequences for the
// shared OBI port arbiter (NREQ=4, MAX_OUTSTANDING=4).
// ---------------------------------------------------------------------------
module tb_cgra_obi_port_arbiter;
  import cgra_obi_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int MAXO  = 4;
  localparam int CNT_W = 32;

`ifdef CGRA_OBI_ARB_STALL_CNT_EN
  localparam logic [31:0] EXP_STALL2 = 32'd5;
`else
  localparam logic [31:0] EXP_STALL2 = 32'd0;
`endif

  logic                            clk_i = 1'b0;
  logic                            rst_ni = 1'b0;
  obi_req_t  [NREQ-1:0]            req_i;
  obi_resp_t [NREQ-1:0]            resp_o;
  obi_req_t                        port_req_o;
  obi_resp_t                       port_resp_i;
  logic                            spurious_o;
  logic      [NREQ-1:0][CNT_W-1:0] stall_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  cgra_obi_port_arbiter #(
    .NREQ(NREQ), .MAX_OUTSTANDING(MAXO), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .resp_o(resp_o),
    .port_req_o(port_req_o), .port_resp_i(port_resp_i),
    .spurious_o(spurious_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct packed {
    logic [3:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        exp_fwd;
    logic [1:0]  exp_sel;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_rv;
    logic        exp_spur;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic [3:0] req, input logic gnt, input logic rv,
                              input logic [31:0] rdata, input logic fwd, input logic [1:0] sel,
                              input logic [3:0] eg, input logic [3:0] erv, input logic es);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.exp_fwd = fwd; v.exp_sel = sel; v.exp_gnt = eg; v.exp_rv = erv; v.exp_spur = es;
    return v;
  endfunction

  function automatic logic [31:0] addr_of(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h10;
  endfunction

  function automatic logic [31:0] wdata_of(input int k);
    return 32'hD000_0000 + 32'(k);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] mask, input logic gnt, input logic rv,
                       input logic [31:0] rdata);
    for (int k = 0; k < NREQ; k++) begin
      req_i[k].req   = mask[k];
      req_i[k].addr  = addr_of(k);
      req_i[k].we    = k[0];
      req_i[k].be    = 4'hF;
      req_i[k].wdata = wdata_of(k);
    end
    port_resp_i.gnt    = gnt;
    port_resp_i.rvalid = rv;
    port_resp_i.rdata  = rdata;
  endtask

  task automatic check_now(input string tag, input logic fwd, input logic [1:0] sel,
                           input logic [3:0] eg, input logic [3:0] erv, input logic es,
                           input logic [31:0] rdata);
    logic [3:0] g;
    logic [3:0] r;
    for (int k = 0; k < NREQ; k++) begin
      g[k] = resp_o[k].gnt;
      r[k] = resp_o[k].rvalid;
    end
    chk({tag, ".port_req"}, 32'(port_req_o.req), 32'(fwd));
    if (fwd) begin
      chk({tag, ".addr"},  port_req_o.addr,  addr_of(int'(sel)));
      chk({tag, ".wdata"}, port_req_o.wdata, wdata_of(int'(sel)));
    end else begin
      chk({tag, ".port_zero"}, 32'(|port_req_o), 32'd0);
    end
    chk({tag, ".gnt"},      32'(g),          32'(eg));
    chk({tag, ".rvalid"},   32'(r),          32'(erv));
    chk({tag, ".spurious"}, 32'(spurious_o), 32'(es));
    for (int k = 0; k < NREQ; k++) begin
      if (erv[k]) begin
        chk({tag, ".rdata"}, resp_o[k].rdata, rdata);
      end
    end
  endtask

  // One cycle: drive at edge+1, check at edge+3, advance to next edge+1.
  task automatic cyc(input string tag, input logic [3:0] mask, input logic gnt, input logic rv,
                     input logic [31:0] rdata, input logic fwd, input logic [1:0] sel,
                     input logic [3:0] eg, input logic [3:0] erv, input logic es);
    drive(mask, gnt, rv, rdata);
    #2;
    check_now(tag, fwd, sel, eg, erv, es, rdata);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(4'b0000, 1'b0, 1'b0, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    // Single requester, round-robin fairness, full FIFO, in-order responses, spurious.
    tbl[0]  = mk(4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
    tbl[1]  = mk(4'b0001, 1'b1, 1'b0, 32'h0,        1'b1, 2'd0, 4'b0001, 4'b0000, 1'b0);
    tbl[2]  = mk(4'b0000, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 2'd0, 4'b0000, 4'b0001, 1'b0);
    tbl[3]  = mk(4'b1111, 1'b1, 1'b0, 32'h0,        1'b1, 2'd1, 4'b0010, 4'b0000, 1'b0);
    tbl[4]  = mk(4'b1111, 1'b1, 1'b0, 32'h0,        1'b1, 2'd2, 4'b0100, 4'b0000, 1'b0);
    tbl[5]  = mk(4'b1111, 1'b1, 1'b0, 32'h0,        1'b1, 2'd3, 4'b1000, 4'b0000, 1'b0);
    tbl[6]  = mk(4'b1111, 1'b1, 1'b0, 32'h0,        1'b1, 2'd0, 4'b0001, 4'b0000, 1'b0);
    tbl[7]  = mk(4'b1111, 1'b1, 1'b1, 32'h0000_00A1, 1'b0, 2'd0, 4'b0000, 4'b0010, 1'b0);
    tbl[8]  = mk(4'b0000, 1'b0, 1'b1, 32'h0000_00A2, 1'b0, 2'd0, 4'b0000, 4'b0100, 1'b0);
    tbl[9]  = mk(4'b0000, 1'b0, 1'b1, 32'h0000_00A3, 1'b0, 2'd0, 4'b0000, 4'b1000, 1'b0);
    tbl[10] = mk(4'b0000, 1'b0, 1'b1, 32'h0000_00A4, 1'b0, 2'd0, 4'b0000, 4'b0001, 1'b0);
    tbl[11] = mk(4'b0000, 1'b0, 1'b1, 32'h0000_00A5, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
    tbl[12] = mk(4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1);

    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      chk($sformatf("reset.stall%0d", k), stall_cnt_o[k], 32'd0);
    end

    for (int i = 0; i < 13; i++) begin
      cyc($sformatf("v%0d", i), tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata,
          tbl[i].exp_fwd, tbl[i].exp_sel, tbl[i].exp_gnt, tbl[i].exp_rv, tbl[i].exp_spur);
    end

    // Lock: req1 held without grant must keep the port even after req0 appears.
    do_reset();
    cyc("lock1", 4'b0010, 1'b0, 1'b0, 32'h0, 1'b1, 2'd1, 4'b0000, 4'b0000, 1'b0);
    cyc("lock2", 4'b0011, 1'b0, 1'b0, 32'h0, 1'b1, 2'd1, 4'b0000, 4'b0000, 1'b0);
    cyc("lock3", 4'b0011, 1'b0, 1'b0, 32'h0, 1'b1, 2'd1, 4'b0000, 4'b0000, 1'b0);
    cyc("lock4", 4'b0011, 1'b1, 1'b0, 32'h0, 1'b1, 2'd1, 4'b0010, 4'b0000, 1'b0);
    // Same-cycle grant to req0 and response to req1.
    cyc("lock5", 4'b0001, 1'b1, 1'b1, 32'h0000_00B1, 1'b1, 2'd0, 4'b0001, 4'b0010, 1'b0);
    cyc("lock6", 4'b0000, 1'b0, 1'b1, 32'h0000_00B2, 1'b0, 2'd0, 4'b0000, 4'b0001, 1'b0);
    cyc("spur1", 4'b0000, 1'b0, 1'b1, 32'h0000_00B3, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
    cyc("out1",  4'b0100, 1'b1, 1'b0, 32'h0, 1'b1, 2'd2, 4'b0100, 4'b0000, 1'b1);
    cyc("out2",  4'b1000, 1'b1, 1'b0, 32'h0, 1'b1, 2'd3, 4'b1000, 4'b0000, 1'b1);

    // Reset with two outstanding: outputs quiet, state cleared.
    rst_ni = 1'b0;
    drive(4'b1111, 1'b1, 1'b1, 32'h0000_00C0);
    #2;
    check_now("inrst", 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 32'h0000_00C0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cyc("post1", 4'b1111, 1'b1, 1'b0, 32'h0, 1'b1, 2'd0, 4'b0001, 4'b0000, 1'b0);
    cyc("post2", 4'b0000, 1'b0, 1'b1, 32'h0000_00C1, 1'b0, 2'd0, 4'b0000, 4'b0001, 1'b0);
    cyc("post3", 4'b0000, 1'b0, 1'b1, 32'h0000_00C2, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
    cyc("post4", 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1);

    // Stall counter: req2 held five cycles with no grant.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc($sformatf("stall%0d", i), 4'b0100, 1'b0, 1'b0, 32'h0, 1'b1, 2'd2,
          4'b0000, 4'b0000, 1'b0);
    end
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    #2;
    chk("stall.cnt2", stall_cnt_o[2], EXP_STALL2);
    chk("stall.cnt0", stall_cnt_o[0], 32'd0);
    chk("stall.cnt1", stall_cnt_o[1], 32'd0);
    chk("stall.cnt3", stall_cnt_o[3], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
